// File: rtl/t05_tree_build_ctrl.sv
// Huffman tree build sequencer: repeatedly scans with the least-value finder,
// writes a merged node and wipes both merged entries until one live entry remains.
module t05_tree_build_ctrl #(
    parameter int unsigned MAX_NODES    = 128,
    parameter int unsigned SCAN_TIMEOUT = 512
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [8:0]  sym_count,
    input  logic        scan_fin,
    input  logic [8:0]  least1,
    input  logic [8:0]  least2,
    input  logic [63:0] sum,
    input  logic        mem_ack,
    output logic        scan_clr,
    output logic        scan_en,
    output logic        mem_req,
    output logic [1:0]  mem_op,
    output logic [8:0]  mem_addr,
    output logic [81:0] mem_data,
    output logic [7:0]  node_idx,
    output logic [8:0]  root_idx,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int unsigned TW = $clog2(SCAN_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_SCAN, S_LATCH, S_WR_NODE,
        S_WIPE1, S_WIPE2, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t         state, state_nx;
    logic [8:0]     live;
    logic [8:0]     l1, l2;
    logic [63:0]    s;
    logic [TW-1:0]  tcnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= S_IDLE;
            live     <= '0;
            node_idx <= '0;
            root_idx <= '0;
            l1       <= '0;
            l2       <= '0;
            s        <= '0;
            tcnt     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        root_idx <= '0;
                        if (sym_count >= 9'd2 && sym_count <= 9'd256) begin
                            live     <= sym_count;
                            node_idx <= '0;
                        end
                    end
                end
                S_CLEAR: tcnt <= '0;
                S_SCAN:  tcnt <= tcnt + 1'b1;
                S_LATCH: begin
                    l1 <= least1;
                    l2 <= least2;
                    s  <= sum;
                end
                S_NEXT: begin
                    node_idx <= node_idx + 1'b1;
                    live     <= live - 1'b1;
                    if (live == 9'd2) root_idx <= {1'b1, node_idx};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        scan_clr = 1'b0;
        scan_en  = 1'b0;
        mem_req  = 1'b0;
        mem_op   = '0;
        mem_addr = '0;
        mem_data = '0;
        busy     = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                busy = 1'b0;
                done = (state == S_DONE);
                err  = (state == S_ERR);
                if (start) begin
                    if (sym_count == 9'd0 || sym_count > 9'd256) state_nx = S_ERR;
                    else if (sym_count == 9'd1)                  state_nx = S_DONE;
                    else                                         state_nx = S_CLEAR;
                end
            end
            S_CLEAR: begin
                scan_clr = 1'b1;
                state_nx = S_SCAN;
            end
            S_SCAN: begin
                scan_en = 1'b1;
                if (scan_fin)                               state_nx = S_LATCH;
                else if (tcnt == TW'(SCAN_TIMEOUT - 1))     state_nx = S_ERR;
            end
            // identical indices mean the finder saw fewer than two live entries
            S_LATCH: state_nx = (least1 == least2) ? S_ERR : S_WR_NODE;
            S_WR_NODE: begin
                mem_req  = 1'b1;
                mem_op   = 2'b00;
                mem_addr = {1'b1, node_idx};
                mem_data = {l1, l2, s};
                if (mem_ack) state_nx = S_WIPE1;
            end
            S_WIPE1: begin
                mem_req  = 1'b1;
                mem_op   = 2'b01;
                mem_addr = l1;
                if (mem_ack) state_nx = S_WIPE2;
            end
            S_WIPE2: begin
                mem_req  = 1'b1;
                mem_op   = 2'b01;
                mem_addr = l2;
                if (mem_ack) state_nx = S_NEXT;
            end
            S_NEXT: begin
                if (live == 9'd2)                          state_nx = S_DONE;
                else if (node_idx == 8'(MAX_NODES - 1))    state_nx = S_ERR;
                else                                       state_nx = S_CLEAR;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_t05_tree_build_ctrl.sv
// Directed bench for t05_tree_build_ctrl with a behavioural finder and
// frequency memory that applies node writes and wipes.
module tb_t05_tree_build_ctrl;
    localparam int FIN_LAT = 385;
    localparam int ACK_DLY = 5;

    logic        clk = 1'b0;
    logic        nrst, start, scan_fin, mem_ack;
    logic [8:0]  sym_count, least1, least2;
    logic [63:0] sum;
    logic        scan_clr, scan_en, mem_req, busy, done, err;
    logic [1:0]  mem_op;
    logic [8:0]  mem_addr, root_idx;
    logic [81:0] mem_data;
    logic [7:0]  node_idx;

    t05_tree_build_ctrl #(.MAX_NODES(128), .SCAN_TIMEOUT(512)) dut (
        .clk(clk), .nrst(nrst), .start(start), .sym_count(sym_count),
        .scan_fin(scan_fin), .least1(least1), .least2(least2), .sum(sum),
        .mem_ack(mem_ack), .scan_clr(scan_clr), .scan_en(scan_en),
        .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_data(mem_data), .node_idx(node_idx), .root_idx(root_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // controls written only by the stimulus process
    logic [63:0] init_freq [0:511];
    bit          load_tog = 1'b0;
    bit          fin_en   = 1'b1;
    int          ack_mode = 0;

    // model state written only by the negedge model process
    logic [63:0] freq [0:511];
    bit          load_seen = 1'b0;
    int          fcnt = 0, scan_cycles = 0, wcnt = 0;
    int          unstable = 0, req_cycles = 0, nlog = 0;
    bit          pend = 1'b0;
    logic [1:0]  h_op;
    logic [8:0]  h_addr;
    logic [81:0] h_data;
    logic [1:0]  lg_op   [0:63];
    logic [8:0]  lg_addr [0:63];
    logic [81:0] lg_data [0:63];

    initial begin
        scan_fin = 1'b0; least1 = '0; least2 = '0; sum = '0; mem_ack = 1'b0;
    end

    always @(negedge clk) begin
        int a, b;
        if (load_tog != load_seen) begin
            load_seen = load_tog;
            for (int i = 0; i < 512; i++) freq[i] = init_freq[i];
        end
        if (scan_clr) begin
            fcnt = 0; scan_cycles = 0; scan_fin = 1'b0;
        end else if (scan_en) begin
            fcnt++; scan_cycles++;
            if (fin_en && fcnt == FIN_LAT) begin
                a = -1; b = -1;
                for (int i = 0; i < 384; i++) begin
                    if (freq[i] != 0) begin
                        if (a < 0 || freq[i] < freq[a]) begin b = a; a = i; end
                        else if (b < 0 || freq[i] < freq[b]) b = i;
                    end
                end
                if (a < 0) a = 0;
                if (b < 0) b = a;
                least1 = 9'(a); least2 = 9'(b);
                sum = freq[a] + freq[b];
                scan_fin = 1'b1;
            end
        end
        if (ack_mode == 0) mem_ack = 1'b1;
        else if (!mem_req) begin mem_ack = 1'b0; wcnt = 0; end
        else if (wcnt == ACK_DLY) begin mem_ack = 1'b1; wcnt = 0; end
        else begin mem_ack = 1'b0; wcnt++; end
        if (mem_req) begin
            req_cycles++;
            if (pend && (mem_op !== h_op || mem_addr !== h_addr || mem_data !== h_data)) unstable++;
            h_op = mem_op; h_addr = mem_addr; h_data = mem_data;
            pend = !mem_ack;
            if (mem_ack) begin
                if (nlog < 64) begin
                    lg_op[nlog] = mem_op; lg_addr[nlog] = mem_addr; lg_data[nlog] = mem_data;
                end
                nlog++;
                if (mem_op == 2'b00) freq[mem_addr] = mem_data[63:0];
                else                 freq[mem_addr] = '0;
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic load(input logic [8:0] i0, input logic [63:0] f0, input logic [8:0] i1, input logic [63:0] f1,
                        input logic [8:0] i2, input logic [63:0] f2, input logic [8:0] i3, input logic [63:0] f3);
        for (int i = 0; i < 512; i++) init_freq[i] = '0;
        init_freq[i0] = f0; init_freq[i1] = f1; init_freq[i2] = f2; init_freq[i3] = f3;
        load_tog = ~load_tog;
        @(negedge clk);
    endtask

    task automatic build(input string tag, input logic [8:0] n);
        @(negedge clk);
        sym_count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20000 && !(done || err); i++) @(negedge clk);
        check({tag, "_ended"}, done | err, 1);
    endtask

    task automatic check_pass(input string tag, input int base, input int k,
                              input logic [8:0] e1, input logic [8:0] e2, input logic [63:0] es);
        int j;
        j = base + 3 * k;
        check({tag, "_wr_op"},    lg_op[j],       2'b00);
        check({tag, "_wr_addr"},  lg_addr[j],     9'h100 + 9'(k));
        check({tag, "_wr_data"},  lg_data[j],     {e1, e2, es});
        check({tag, "_w1_op"},    lg_op[j+1],     2'b01);
        check({tag, "_w1_addr"},  lg_addr[j+1],   e1);
        check({tag, "_w1_data"},  lg_data[j+1],   82'd0);
        check({tag, "_w2_op"},    lg_op[j+2],     2'b01);
        check({tag, "_w2_addr"},  lg_addr[j+2],   e2);
    endtask

    task automatic run_four(input string tag, input int exp_req);
        int base, r0, u0;
        load(9'd0, 64'd1, 9'd1, 64'd1, 9'd2, 64'd2, 9'd3, 64'd4);
        base = nlog; r0 = req_cycles; u0 = unstable;
        build(tag, 9'd4);
        check({tag, "_done"},     done, 1);
        check({tag, "_err"},      err, 0);
        check({tag, "_nxfer"},    nlog - base, 9);
        check_pass({tag, "_p0"}, base, 0, 9'h000, 9'h001, 64'd2);
        check_pass({tag, "_p1"}, base, 1, 9'h002, 9'h100, 64'd4);
        check_pass({tag, "_p2"}, base, 2, 9'h003, 9'h101, 64'd8);
        check({tag, "_root"},     root_idx, 9'h102);
        check({tag, "_node_idx"}, node_idx, 8'd3);
        check({tag, "_req_cyc"},  req_cycles - r0, exp_req);
        check({tag, "_stable"},   unstable - u0, 0);
    endtask

    initial begin
        int base, r0;
        nrst = 1'b0; start = 1'b1; sym_count = 9'd2;
        for (int i = 0; i < 512; i++) init_freq[i] = '0;

        // reset, with start held high throughout
        repeat (2) @(negedge clk);
        check("rst_ctrl", {scan_clr, scan_en, mem_req, mem_op, busy, done, err}, 0);
        check("rst_mem",  {mem_addr, mem_data}, 0);
        check("rst_idx",  {node_idx, root_idx}, 0);
        start = 1'b0; nrst = 1'b1;
        @(negedge clk);
        check("rst_idle", {busy, done, err}, 0);

        // two symbols
        load(9'h061, 64'd3, 9'h062, 64'd5, 9'h1ff, 64'd0, 9'h1fe, 64'd0);
        base = nlog;
        build("two", 9'd2);
        check("two_done", {done, err, busy}, 3'b100);
        check("two_nxfer", nlog - base, 3);
        check_pass("two", base, 0, 9'h061, 9'h062, 64'd8);
        check("two_root", root_idx, 9'h100);
        check("two_node_idx", node_idx, 8'd1);

        // four symbols, ack tied high then delayed
        ack_mode = 0;
        run_four("four", 9);
        ack_mode = 1;
        run_four("slow", 9 * (ACK_DLY + 1));
        ack_mode = 0;

        // finder never finishes
        load(9'h061, 64'd3, 9'h062, 64'd5, 9'h1ff, 64'd0, 9'h1fe, 64'd0);
        fin_en = 1'b0;
        r0 = req_cycles;
        build("tmo", 9'd2);
        check("tmo_err", {err, done, busy}, 3'b100);
        check("tmo_cycles", scan_cycles, 512);
        check("tmo_noreq", req_cycles - r0, 0);
        fin_en = 1'b1;

        // out-of-range symbol counts, then single symbol clears err
        build("zero", 9'd0);
        check("zero_err", {err, done}, 2'b10);
        build("big", 9'd257);
        check("big_err", {err, done}, 2'b10);
        build("one", 9'd1);
        check("one_done", {done, err, root_idx}, {2'b10, 9'h000});

        // reset during the first wipe
        ack_mode = 1;
        load(9'h061, 64'd3, 9'h062, 64'd5, 9'h1ff, 64'd0, 9'h1fe, 64'd0);
        @(negedge clk);
        sym_count = 9'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && !(mem_req && mem_op == 2'b01); i++) @(negedge clk);
        check("mid_wipe_seen", {mem_req, mem_op}, 3'b101);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check("mid_rst", {mem_req, busy, done, err}, 0);
        ack_mode = 0;
        sym_count = 9'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_one", {done, err, busy, root_idx}, {3'b100, 9'h000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
